// File: rtl/path_reader.sv
// Drains a replay-ordered location stack and turns each adjacent step between
// consecutive locations into a 2-bit move command on a valid/ready handshake.
module path_reader #(
  parameter int COORD_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*COORD_W-1:0] locIn,
  input  logic                 empStck,
  output logic                 pop,
  output logic [1:0]           dirOut,
  output logic                 dirValid,
  input  logic                 dirReady,
  output logic                 busy,
  output logic                 finished,
  output logic                 error,
  output logic [CNT_W-1:0]     stepCount
);

  localparam int LOC_W = 2 * COORD_W;
  localparam logic [COORD_W:0] ONE_C = (COORD_W+1)'(1);
  localparam logic [CNT_W-1:0] ONE_N = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_FETCH,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LOC_W-1:0]   prev_q, prev_d;
  logic [LOC_W-1:0]   cur_q, cur_d;
  logic               first_q, first_d;
  logic [1:0]         dir_q, dir_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               finished_q, finished_d;

  // Coordinates widened by one bit so +1 never wraps (15 -> 0 is not adjacent).
  logic [COORD_W:0] x_c, y_c, x_p, y_p;
  logic             same_x, same_y;
  logic             step_xp, step_xm, step_yp, step_ym;

  always_comb begin
    x_c     = {1'b0, locIn[LOC_W-1:COORD_W]};
    y_c     = {1'b0, locIn[COORD_W-1:0]};
    x_p     = {1'b0, prev_q[LOC_W-1:COORD_W]};
    y_p     = {1'b0, prev_q[COORD_W-1:0]};
    same_x  = (x_c == x_p);
    same_y  = (y_c == y_p);
    step_xp = same_y && (x_c == x_p + ONE_C);
    step_xm = same_y && (x_p == x_c + ONE_C);
    step_yp = same_x && (y_c == y_p + ONE_C);
    step_ym = same_x && (y_p == y_c + ONE_C);
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    first_d = first_q;
    dir_d   = dir_q;
    valid_d = valid_q;
    error_d = error_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CHECK;
          error_d = 1'b0;
          cnt_d   = '0;
          first_d = 1'b1;
        end
      end
      S_CHECK: state_d = empStck ? S_DONE : S_FETCH;
      S_FETCH: begin
        cur_d = locIn;
        if (first_q) begin
          prev_d  = locIn;
          first_d = 1'b0;
          state_d = S_CHECK;
        end else if (locIn == prev_q) begin
          state_d = S_CHECK;
        end else if (step_xp || step_xm || step_yp || step_ym) begin
          if (step_xp)      dir_d = 2'b00;
          else if (step_xm) dir_d = 2'b01;
          else if (step_yp) dir_d = 2'b10;
          else              dir_d = 2'b11;
          valid_d = 1'b1;
          state_d = S_EMIT;
        end else begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_EMIT: begin
        if (dirReady) begin
          prev_d  = cur_q;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + ONE_N;
          valid_d = 1'b0;
          state_d = S_CHECK;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d     = (state_d == S_CHECK) || (state_d == S_FETCH) || (state_d == S_EMIT);
    finished_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      prev_q     <= '0;
      cur_q      <= '0;
      first_q    <= 1'b1;
      dir_q      <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      first_q    <= first_d;
      dir_q      <= dir_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
    end
  end

  // Pop must land in the CHECK cycle itself so data arrives in FETCH.
  assign pop       = (state_q == S_CHECK) && !empStck;
  assign dirOut    = dir_q;
  assign dirValid  = valid_q;
  assign busy      = busy_q;
  assign finished  = finished_q;
  assign error     = error_q;
  assign stepCount = cnt_q;

endmodule

// File: tb/tb_path_reader.sv
// Randomized and directed bench for path_reader with a queue-based stack model
// and a list-walking reference of the expected move sequence.
module tb_path_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] loc_in = '0;
  logic       emp;
  logic       pop;
  logic [1:0] dir_out;
  logic       dir_valid;
  logic       dir_ready = 1'b0;
  logic       busy, finished, error;
  logic [7:0] step_count;

  int vectors = 0;
  int errs = 0;

  path_reader #(.COORD_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst_n), .start(start), .locIn(loc_in), .empStck(emp),
    .pop(pop), .dirOut(dir_out), .dirValid(dir_valid), .dirReady(dir_ready),
    .busy(busy), .finished(finished), .error(error), .stepCount(step_count)
  );

  always #5 clk = ~clk;

  // Stack model: a pop at a rising edge presents the next entry one cycle later.
  logic [7:0] stk [0:511];
  int stk_depth = 0;
  int stk_rd = 0;
  logic stk_clr = 1'b0;
  assign emp = (stk_rd >= stk_depth);

  always @(posedge clk) begin
    if (stk_clr) stk_rd <= 0;
    else if (pop) begin
      loc_in <= stk[stk_rd];
      stk_rd <= stk_rd + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: walk the location list with the stepping rules.
  logic [7:0] path [$];
  logic [1:0] exp_moves [$];
  logic [1:0] got_moves [$];
  bit exp_err;
  int exp_pops;

  task automatic model();
    bit   first;
    logic [7:0] prev, c;
    int   dx, dy;
    first = 1;
    prev = '0;
    exp_moves.delete();
    exp_err = 0;
    exp_pops = 0;
    foreach (path[i]) begin
      c = path[i];
      exp_pops++;
      if (first) begin
        prev = c;
        first = 0;
        continue;
      end
      if (c == prev) continue;
      dx = int'(c[7:4]) - int'(prev[7:4]);
      dy = int'(c[3:0]) - int'(prev[3:0]);
      if (dy == 0 && dx == 1)       exp_moves.push_back(2'b00);
      else if (dy == 0 && dx == -1) exp_moves.push_back(2'b01);
      else if (dx == 0 && dy == 1)  exp_moves.push_back(2'b10);
      else if (dx == 0 && dy == -1) exp_moves.push_back(2'b11);
      else begin
        exp_err = 1;
        break;
      end
      prev = c;
    end
  endtask

  // Monitor/driver at the falling edge: protocol checks, ready driving, move capture.
  int ready_mode = 0;
  int stall_cnt = 0;
  int pops_seen = 0;
  bit prev_stall = 0;
  bit prev_pop = 0;
  logic [1:0] prev_dir = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 0;
      prev_pop = 0;
      stall_cnt = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", dir_valid, 1'b1);
        chk("stall_dir", dir_out, prev_dir);
      end
      if (pop) begin
        pops_seen++;
        chk("pop_when_empty", emp, 1'b0);
        chk("pop_back_to_back", prev_pop, 1'b0);
      end
      prev_pop = pop;
      case (ready_mode)
        0: dir_ready = 1'b1;
        1: dir_ready = 1'($urandom_range(0, 1));
        2: begin
          if (!dir_valid) stall_cnt = 0;
          dir_ready = (stall_cnt >= 5);
          if (dir_valid) stall_cnt++;
        end
        default: dir_ready = 1'b0;
      endcase
      if (dir_valid && dir_ready) got_moves.push_back(dir_out);
      prev_stall = dir_valid && !dir_ready;
      prev_dir = dir_out;
    end
  end

  task automatic load_stack();
    foreach (path[i]) stk[i] = path[i];
    stk_depth = path.size();
    @(posedge clk); #1 stk_clr = 1'b1;
    @(posedge clk); #1 stk_clr = 1'b0;
  endtask

  task automatic run_path(input int mode, input bit restart_mid);
    int n;
    int exp_cnt;
    model();
    load_stack();
    ready_mode = mode;
    got_moves.delete();
    pops_seen = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("start_busy", busy, 1'b1);
    chk("start_err_clr", error, 1'b0);
    chk("start_cnt_clr", step_count, 8'd0);
    if (restart_mid) begin
      @(posedge clk); #1 start = busy;
      @(posedge clk); #1 start = 1'b0;
    end
    n = 0;
    while (!finished && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", finished, 1'b1);
    chk("move_count", got_moves.size(), exp_moves.size());
    foreach (exp_moves[i])
      if (i < got_moves.size()) chk("move", got_moves[i], exp_moves[i]);
    exp_cnt = (exp_moves.size() > 255) ? 255 : exp_moves.size();
    chk("step_count", step_count, exp_cnt);
    chk("error", error, exp_err);
    chk("pops", pops_seen, exp_pops);
    chk("busy_done", busy, 1'b0);
    chk("valid_done", dir_valid, 1'b0);
    if (exp_moves.size() > 0) chk("dir_hold", dir_out, exp_moves[exp_moves.size()-1]);
  endtask

  task automatic check_reset_outputs();
    chk("rst_pop", pop, 1'b0);
    chk("rst_dir", dir_out, 2'b00);
    chk("rst_valid", dir_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_finished", finished, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_cnt", step_count, 8'd0);
  endtask

  initial begin
    int n;
    int x, y, nx, ny, r, len;
    path.delete();
    stk_depth = 1;
    #23;
    check_reset_outputs();
    rst_n = 1'b1;

    path = '{8'h00, 8'h10, 8'h11, 8'h21};
    run_path(0, 0);
    run_path(2, 0);
    path = '{8'h00, 8'h22};
    run_path(0, 0);
    path = '{8'h00, 8'h10, 8'h11, 8'h21};
    run_path(1, 0);
    path = '{8'hF0, 8'h00};
    run_path(0, 0);
    path.delete();
    run_path(0, 0);
    path = '{8'h33, 8'h33, 8'h32};
    run_path(1, 0);

    // Asynchronous reset while a move is being held by backpressure.
    path = '{8'h00, 8'h10, 8'h20};
    load_stack();
    ready_mode = 3;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!dir_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("emit_reached", dir_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    path = '{8'h55, 8'h65, 8'h64};
    run_path(0, 0);

    for (int t = 0; t < 40; t++) begin
      path.delete();
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
      path.push_back({x[3:0], y[3:0]});
      len = $urandom_range(0, 12);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 11);
        nx = x;
        ny = y;
        case (r)
          0: ;
          1: begin nx = $urandom_range(0, 15); ny = $urandom_range(0, 15); end
          2, 3, 4: nx = x + 1;
          5, 6: nx = x - 1;
          7, 8: ny = y + 1;
          default: ny = y - 1;
        endcase
        x = nx & 15;
        y = ny & 15;
        path.push_back({x[3:0], y[3:0]});
      end
      run_path($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Long oscillating path drives the step counter into saturation.
    path.delete();
    for (int k = 0; k < 300; k++) path.push_back((k % 2 == 0) ? 8'h40 : 8'h50);
    run_path(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
